// File: rtl/zero_run_cntr.sv
// zero_run_cntr: per-channel zero-sample counters (cumulative or run-length), threshold pulse,
// sticky limit flag and registered readout. Define ZCNT_SAT_EN for saturating counters; default wraps.
module zero_run_cntr #(
    parameter int NCH = 4,
    parameter int DW  = 7,
    parameter int CW  = 4,
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    // in_valid qualifies in_data for every channel; there is no ready, every valid cycle is consumed.
    input  logic              in_valid,
    input  logic [NCH*DW-1:0] in_data,
    input  logic              mode,
    input  logic              clr,
    input  logic [CW-1:0]     thresh,
    input  logic [SW-1:0]     rd_sel,
    output logic [CW-1:0]     zcnt_out,
    output logic [NCH-1:0]    hit,
    output logic [NCH-1:0]    flag
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [NCH-1:0] hit_q;
    logic [NCH-1:0] hit_d;
    logic [NCH-1:0] flag_q;
    logic [NCH-1:0] flag_d;
    logic [CW-1:0]  zcnt_out_q;
    logic [CW-1:0]  zcnt_out_d;
    logic [NCH-1:0] is_zero;
    logic [NCH-1:0] at_max;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            is_zero[i] = (in_data[i*DW +: DW] == '0);
            at_max[i]  = (cnt_q[i] == CNT_MAX);
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i]  = cnt_q[i];
            flag_d[i] = flag_q[i];
            hit_d[i]  = 1'b0;
            if (clr) begin
                cnt_d[i]  = '0;
                flag_d[i] = 1'b0;
            end else if (in_valid) begin
                if (is_zero[i]) begin
                    if (at_max[i]) begin
                        flag_d[i] = 1'b1;
`ifdef ZCNT_SAT_EN
                        cnt_d[i] = CNT_MAX;
`else
                        cnt_d[i] = '0;
`endif
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end else if (mode) begin
                    cnt_d[i] = '0;
                end
                // Pulse only on the transition into thresh, so a held count does not re-fire.
                hit_d[i] = (thresh != '0) && (cnt_d[i] == thresh) && (cnt_q[i] != thresh);
            end
        end
    end

    // Readout samples the pre-update counter; out-of-range selects read as zero.
    always_comb begin
        zcnt_out_d = '0;
        if (int'(rd_sel) < NCH) begin
            zcnt_out_d = cnt_q[rd_sel];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
            hit_q      <= '0;
            flag_q     <= '0;
            zcnt_out_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            hit_q      <= hit_d;
            flag_q     <= flag_d;
            zcnt_out_q <= zcnt_out_d;
        end
    end

    assign zcnt_out = zcnt_out_q;
    assign hit      = hit_q;
    assign flag     = flag_q;

endmodule
